// File: rtl/osc_multiwave_core.sv
// Multi-waveform oscillator: phase accumulator feeding square/tri/saw/sine generators,
// three-stage pipeline (phase, per-wave registers + LUT read, output mux).
module osc_multiwave_core #(
  parameter int WAVE_WIDTH_P  = 24,
  parameter int PHASE_WIDTH_P = 32,
  parameter int SINE_ADDR_P   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [WAVE_WIDTH_P-1:0]  waveform,
  output logic                     waveform_valid,
  input  logic                     cr_enable,
  input  logic                     cr_sync,
  input  logic [1:0]               cr_waveform_select,
  input  logic [PHASE_WIDTH_P-1:0] cr_phase_inc,
  input  logic [PHASE_WIDTH_P-1:0] cr_duty_cycle
);
  localparam int W     = WAVE_WIDTH_P;
  localparam int P     = PHASE_WIDTH_P;
  localparam int A     = SINE_ADDR_P;
  localparam int LUT_N = 1 << A;
  localparam logic [W-1:0] WMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] WMIN = {1'b1, {(W-1){1'b0}}};
  localparam real HALF_PI = 1.5707963267948966;

  typedef struct packed {
    logic [W-1:0] sq;
    logic [W-1:0] saw;
    logic [W-1:0] trg;
    logic [W-2:0] mag;
    logic         neg;
    logic [1:0]   sel;
  } s1_t;

  logic [P-1:0]   phase;
  logic [1:0]     sel0;
  s1_t            s1;
  logic [1:0]     vld_pipe;
  logic [W-1:0]   wave_nxt;
  logic [P+W-2:0] lo_ext;
  logic [W-1:0]   tri_t;
  logic [W-1:0]   tri_c;
  logic [W-2:0]   saw_lo;
  logic [A-1:0]   addr;

  // Quarter-wave ROM; the half-step offset keeps mirrored quadrants exact.
  logic [W-2:0] lut [LUT_N];
  for (genvar i = 0; i < LUT_N; i++) begin : g_lut
    localparam real ANG = HALF_PI * (real'(i) + 0.5) / real'(LUT_N);
    localparam int  VAL = $rtoi(real'(WMAX) * $sin(ANG) + 0.5);
    assign lut[i] = VAL[W-2:0];
  end

  // S0: phase accumulator, sync wins over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      sel0  <= '0;
    end else begin
      sel0 <= cr_waveform_select;
      if (cr_sync)        phase <= '0;
      else if (cr_enable) phase <= phase + cr_phase_inc;
    end
  end

  // Low phase bits padded with zeros so narrow accumulators still yield W-bit slices.
  assign lo_ext = {phase[P-2:0], {W{1'b0}}};
  assign saw_lo = (W-1)'(lo_ext >> P);
  assign tri_t  = W'(lo_ext >> (P-1)) ^ {W{phase[P-1]}};
  assign tri_c  = {~tri_t[W-1], tri_t[W-2:0]};
  assign addr   = A'(lo_ext >> (P+W-2-A)) ^ {A{phase[P-2]}};

  // S1: every generator registered in parallel so a select change never mixes waves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], cr_enable};
      s1.sq    <= (phase < cr_duty_cycle) ? WMAX : WMIN;
      s1.saw   <= {~phase[P-1], saw_lo};
      s1.trg   <= tri_c;
      s1.mag   <= lut[addr];
      s1.neg   <= phase[P-1];
      s1.sel   <= sel0;
    end
  end

  always_comb begin
    wave_nxt = s1.sq;
    case (s1.sel)
      2'd1:    wave_nxt = s1.trg;
      2'd2:    wave_nxt = s1.saw;
      2'd3:    wave_nxt = s1.neg ? -{1'b0, s1.mag} : {1'b0, s1.mag};
      default: wave_nxt = s1.sq;
    endcase
  end

  // S2: output only advances on enabled samples, so it rests at 0 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           waveform <= '0;
    else if (vld_pipe[0]) waveform <= wave_nxt;
  end

  assign waveform_valid = vld_pipe[1];

endmodule

// File: tb/tb_osc_multiwave_core.sv
// Directed + randomized bench for osc_multiwave_core (P=16, W=16, A=6) against an
// arithmetic reference model of each waveform.
module tb_osc_multiwave_core;
  localparam int  W  = 16;
  localparam int  P  = 16;
  localparam int  A  = 6;
  localparam real PI = 3.141592653589793;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  waveform;
  logic          waveform_valid;
  logic          cr_enable = 1'b0;
  logic          cr_sync = 1'b0;
  logic [1:0]    cr_waveform_select = 2'd0;
  logic [P-1:0]  cr_phase_inc = '0;
  logic [P-1:0]  cr_duty_cycle = '0;

  osc_multiwave_core #(.WAVE_WIDTH_P(W), .PHASE_WIDTH_P(P), .SINE_ADDR_P(A)) dut (
    .clk(clk), .rst_n(rst_n),
    .waveform(waveform), .waveform_valid(waveform_valid),
    .cr_enable(cr_enable), .cr_sync(cr_sync),
    .cr_waveform_select(cr_waveform_select),
    .cr_phase_inc(cr_phase_inc), .cr_duty_cycle(cr_duty_cycle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // History of sampled inputs / resulting phase: index 0 = last edge, 1 = edge before.
  logic [15:0] ph_h [2];
  logic [1:0]  sel_h [2];
  logic        en_h;
  logic [15:0] duty_h;
  logic [15:0] exp_wave;
  logic        exp_valid;
  logic [15:0] samp [64];

  function automatic logic [15:0] ref_wave(input logic [15:0] ph, input logic [1:0] sel,
                                           input logic [15:0] duty);
    int  p;
    real v;
    p = int'(ph);
    case (sel)
      2'd0: ref_wave = (ph < duty) ? 16'h7FFF : 16'h8000;
      2'd1: ref_wave = (p < 32768) ? 16'(2*p - 32768) : 16'(32767 - 2*(p - 32768));
      2'd2: ref_wave = 16'(p - 32768);
      default: begin
        v = 32767.0 * $sin(2.0 * PI * (real'(p / 256) + 0.5) / 256.0);
        ref_wave = (v >= 0.0) ? 16'($rtoi(v + 0.5)) : 16'(-$rtoi(-v + 0.5));
      end
    endcase
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    ph_h[0] = '0; ph_h[1] = '0;
    sel_h[0] = '0; sel_h[1] = '0;
    en_h = 1'b0; duty_h = '0;
    exp_wave = '0; exp_valid = 1'b0;
  endtask

  // One clock: model the edge from the inputs it sampled, then compare outputs.
  task automatic step();
    logic [15:0] nph;
    @(posedge clk);
    if (en_h) exp_wave = ref_wave(ph_h[1], sel_h[1], duty_h);
    exp_valid = en_h;
    nph = cr_sync ? 16'h0 : (cr_enable ? 16'(ph_h[0] + cr_phase_inc) : ph_h[0]);
    ph_h[1] = ph_h[0];  ph_h[0] = nph;
    sel_h[1] = sel_h[0]; sel_h[0] = cr_waveform_select;
    en_h = cr_enable;   duty_h = cr_duty_cycle;
    #1;
    check16("wave", waveform, exp_wave);
    check16("valid", {15'b0, waveform_valid}, {15'b0, exp_valid});
  endtask

  task automatic sync_start(input logic [1:0] sel, input logic [15:0] inc);
    cr_enable = 1'b1; cr_sync = 1'b1; cr_waveform_select = sel; cr_phase_inc = inc;
    step();
    cr_sync = 1'b0;
    step();
  endtask

  initial begin
    int mi;
    mdl_reset();
    #3;
    check16("reset_wave", waveform, 16'h0);
    check16("reset_valid", {15'b0, waveform_valid}, 16'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Reset/valid: enable off for two cycles, then on
    cr_phase_inc = 16'h1000; cr_waveform_select = 2'd2; cr_duty_cycle = 16'h4000;
    step(); step();
    cr_enable = 1'b1;
    step();
    check16("valid_lat1_wave", waveform, 16'h0);
    check16("valid_lat1_valid", {15'b0, waveform_valid}, 16'h0);
    step();
    check16("valid_rise", {15'b0, waveform_valid}, 16'h1);
    check16("saw_first", waveform, 16'h8000);
    for (int n = 1; n < 20; n++) begin
      step();
      check16("saw_seq", waveform, 16'(16'h8000 + 16'h1000 * n));
    end

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check16("async_rst_wave", waveform, 16'h0);
    check16("async_rst_valid", {15'b0, waveform_valid}, 16'h0);
    mdl_reset();
    @(negedge clk) rst_n = 1'b1;

    // Square, duty 0x4000 then 0
    cr_duty_cycle = 16'h4000;
    sync_start(2'd0, 16'h1000);
    for (int n = 0; n < 32; n++) begin
      step();
      check16("square_duty", waveform, ((n % 16) < 4) ? 16'h7FFF : 16'h8000);
    end
    cr_duty_cycle = 16'h0;
    step(); step();
    for (int n = 0; n < 16; n++) begin
      step();
      check16("square_duty0", waveform, 16'h8000);
    end

    // Triangle
    sync_start(2'd1, 16'h1000);
    for (int n = 0; n < 16; n++) begin
      step();
      samp[n] = waveform;
    end
    check16("tri_0000", samp[0], 16'h8000);
    check16("tri_4000", samp[4], 16'h0000);
    check16("tri_7000", samp[7], 16'h6000);
    check16("tri_8000", samp[8], 16'h7FFF);
    check16("tri_C000", samp[12], 16'hFFFF);

    // Sine
    sync_start(2'd3, 16'h0400);
    for (int n = 0; n < 64; n++) begin
      step();
      samp[n] = waveform;
    end
    check16("sine_first", samp[0], 16'h0192);
    for (int n = 0; n < 32; n++) check16("sine_mirror", samp[n+32], 16'(-samp[n]));
    mi = 0;
    for (int n = 1; n < 64; n++) if ($signed(samp[n]) > $signed(samp[mi])) mi = n;
    check16("sine_max_idx", 16'(mi), 16'd16);
    check16("sine_max_ge", {15'b0, $signed(samp[mi]) >= 16'sh7FF0}, 16'h1);

    // Sync + select change mid-saw
    cr_duty_cycle = 16'h3000; cr_waveform_select = 2'd2; cr_phase_inc = 16'h0D37;
    for (int n = 0; n < 7; n++) step();
    cr_sync = 1'b1; cr_waveform_select = 2'd0;
    step();
    cr_sync = 1'b0;
    step();
    step();
    check16("sync_square_restart", waveform, 16'h7FFF);

    // Sync with enable low still zeroes the phase
    cr_enable = 1'b0; step(); step();
    cr_sync = 1'b1; cr_waveform_select = 2'd2; cr_phase_inc = 16'h1000;
    step();
    cr_sync = 1'b0; cr_enable = 1'b1;
    step(); step();
    check16("sync_en_low", waveform, 16'h8000);
    check16("sync_en_low_valid", {15'b0, waveform_valid}, 16'h1);

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      cr_enable = ($urandom_range(0, 7) != 0);
      cr_sync   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) cr_waveform_select = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) cr_phase_inc = 16'($urandom);
      if ($urandom_range(0, 15) == 0) cr_duty_cycle = 16'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
